reorder_buffer: RTL and testbench

Circular reorder buffer sitting directly after the rename stage (architectural-to-physical register mapping) in the out-of-order RISC-V core. Dispatch allocates one entry per renamed instruction in program order. Execution writeback marks entries done. The head entry retires in order and drives the commit interface the rename stage consumes (`commit_valid`, `commit_with_write`, `commited_wr_register`) to return the previous physical mapping to the free list.

---
 rtl/reorder_buffer_pkg.sv | 26 ++
 rtl/reorder_buffer_circ_ptr.sv | 20 ++
 rtl/reorder_buffer.sv | 139 +++++++++++++
 tb/tb_reorder_buffer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types and default widths for the reorder buffer.
// Widths fall back to 5/6 when the core-wide width macros are not already defined.
`ifndef ARCH_REG_NUM_WIDTH
`define ARCH_REG_NUM_WIDTH 5
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif

package reorder_buffer_pkg;
  localparam int ROB_DEPTH_W_DEF = 4;
  localparam int ROB_ENTRIES     = 2**ROB_DEPTH_W_DEF;
  localparam int ARCH_W          = `ARCH_REG_NUM_WIDTH;
  localparam int PHY_W           = `PHYSICAL_REG_NUM_WIDTH;

  typedef logic [ROB_DEPTH_W_DEF-1:0] rob_tag_t;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              with_write;
    logic [ARCH_W-1:0] arch_rd;
    logic [PHY_W-1:0]  phy_rd;
    logic [PHY_W-1:0]  old_phy_rd;
  } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_circ_ptr.sv
// Wrapping pointer with increment enable and synchronous clear; used for ROB head and tail.
module rob_circ_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_ptr
);
  logic [W-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_ptr <= '0;
    else if (i_clr) r_ptr <= '0;
    else if (i_inc) r_ptr <= r_ptr + W'(1);
  end

  assign o_ptr = r_ptr;
endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order complete, in-order commit.
// Define ROB_COMPLETE_BYPASS_EN to let a completion of the head entry commit on the same edge.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_DEPTH_WIDTH        = ROB_DEPTH_W_DEF,
  parameter int ARCH_REG_NUM_WIDTH     = `ARCH_REG_NUM_WIDTH,
  parameter int PHYSICAL_REG_NUM_WIDTH = `PHYSICAL_REG_NUM_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              alloc_valid,
  input  logic                              alloc_with_write,
  input  logic [ARCH_REG_NUM_WIDTH-1:0]     alloc_arch_rd,
  input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_phy_rd,
  input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_old_phy_rd,
  output logic                              alloc_ready,
  output logic [ROB_DEPTH_WIDTH-1:0]        alloc_tag,
  input  logic                              complete_valid,
  input  logic [ROB_DEPTH_WIDTH-1:0]        complete_tag,
  input  logic                              flush,
  output logic                              commit_valid,
  output logic                              commit_with_write,
  output logic [PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register,
  output logic [ARCH_REG_NUM_WIDTH-1:0]     commit_arch_rd,
  output logic [PHYSICAL_REG_NUM_WIDTH-1:0] commit_phy_rd,
  output logic                              rob_empty,
  output logic [ROB_DEPTH_WIDTH:0]          rob_count
);
  localparam int N = 2**ROB_DEPTH_WIDTH;
  localparam logic [ROB_DEPTH_WIDTH:0] FULL_CNT = (ROB_DEPTH_WIDTH+1)'(N);

  rob_entry_t                        r_entries [N];
  logic [ROB_DEPTH_WIDTH:0]          r_count;
  logic                              r_commit_valid;
  logic                              r_commit_with_write;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] r_commit_old_phy;
  logic [ARCH_REG_NUM_WIDTH-1:0]     r_commit_arch;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] r_commit_phy;

  logic [ROB_DEPTH_WIDTH-1:0] w_head;
  logic [ROB_DEPTH_WIDTH-1:0] w_tail;
  rob_entry_t                 w_head_entry;
  logic                       w_full;
  logic                       w_alloc;
  logic                       w_head_done;
  logic                       w_commit;

  rob_circ_ptr #(.W(ROB_DEPTH_WIDTH)) u_head_ptr (
    .clk   (clk),
    .rst_n (reset),
    .i_inc (w_commit),
    .i_clr (flush),
    .o_ptr (w_head)
  );

  rob_circ_ptr #(.W(ROB_DEPTH_WIDTH)) u_tail_ptr (
    .clk   (clk),
    .rst_n (reset),
    .i_inc (w_alloc),
    .i_clr (flush),
    .o_ptr (w_tail)
  );

  assign w_full       = (r_count == FULL_CNT);
  assign w_alloc      = alloc_valid && !w_full && !flush;
  assign w_head_entry = r_entries[w_head];

`ifdef ROB_COMPLETE_BYPASS_EN
  assign w_head_done = w_head_entry.done || (complete_valid && (complete_tag == w_head));
`else
  assign w_head_done = w_head_entry.done;
`endif

  assign w_commit = !flush && w_head_entry.valid && w_head_done;

  // Later assignments win: an allocation may reuse the slot a commit just freed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) r_entries[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) r_entries[i].valid <= 1'b0;
    end else begin
      if (complete_valid && r_entries[complete_tag].valid)
        r_entries[complete_tag].done <= 1'b1;
      if (w_commit)
        r_entries[w_head].valid <= 1'b0;
      if (w_alloc)
        r_entries[w_tail] <= '{valid:      1'b1,
                               done:       1'b0,
                               with_write: alloc_with_write,
                               arch_rd:    alloc_arch_rd,
                               phy_rd:     alloc_phy_rd,
                               old_phy_rd: alloc_old_phy_rd};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + (ROB_DEPTH_WIDTH+1)'(1);
        2'b01:   r_count <= r_count - (ROB_DEPTH_WIDTH+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_commit_valid      <= 1'b0;
      r_commit_with_write <= 1'b0;
      r_commit_old_phy    <= '0;
      r_commit_arch       <= '0;
      r_commit_phy        <= '0;
    end else begin
      r_commit_valid <= w_commit;
      if (w_commit) begin
        r_commit_with_write <= w_head_entry.with_write;
        r_commit_old_phy    <= w_head_entry.old_phy_rd;
        r_commit_arch       <= w_head_entry.arch_rd;
        r_commit_phy        <= w_head_entry.phy_rd;
      end
    end
  end

  assign alloc_ready          = !w_full;
  assign alloc_tag            = w_tail;
  assign rob_empty            = (r_count == '0);
  assign rob_count            = r_count;
  assign commit_valid         = r_commit_valid;
  assign commit_with_write    = r_commit_with_write;
  assign commited_wr_register = r_commit_old_phy;
  assign commit_arch_rd       = r_commit_arch;
  assign commit_phy_rd        = r_commit_phy;
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized traffic vs a queue model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int N = 16;
`ifdef ROB_COMPLETE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       alloc_valid = 1'b0;
  logic       alloc_with_write = 1'b0;
  logic [4:0] alloc_arch_rd = '0;
  logic [5:0] alloc_phy_rd = '0;
  logic [5:0] alloc_old_phy_rd = '0;
  logic       alloc_ready;
  logic [3:0] alloc_tag;
  logic       complete_valid = 1'b0;
  logic [3:0] complete_tag = '0;
  logic       flush = 1'b0;
  logic       commit_valid;
  logic       commit_with_write;
  logic [5:0] commited_wr_register;
  logic [4:0] commit_arch_rd;
  logic [5:0] commit_phy_rd;
  logic       rob_empty;
  logic [4:0] rob_count;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk                  (clk),
    .reset                (reset),
    .alloc_valid          (alloc_valid),
    .alloc_with_write     (alloc_with_write),
    .alloc_arch_rd        (alloc_arch_rd),
    .alloc_phy_rd         (alloc_phy_rd),
    .alloc_old_phy_rd     (alloc_old_phy_rd),
    .alloc_ready          (alloc_ready),
    .alloc_tag            (alloc_tag),
    .complete_valid       (complete_valid),
    .complete_tag         (complete_tag),
    .flush                (flush),
    .commit_valid         (commit_valid),
    .commit_with_write    (commit_with_write),
    .commited_wr_register (commited_wr_register),
    .commit_arch_rd       (commit_arch_rd),
    .commit_phy_rd        (commit_phy_rd),
    .rob_empty            (rob_empty),
    .rob_count            (rob_count)
  );

  // Reference model: program-order queue of in-flight instructions plus per-tag done flags.
  typedef struct {
    int tag;
    int ww;
    int arch;
    int phy;
    int old;
  } ment_t;

  ment_t mq[$];
  int    mdone[N];
  int    mtail;
  int    e_cv, e_ww, e_arch, e_phy, e_free;
  int    n_chk = 0;
  int    n_pass = 0;
  int    obs_free[$];

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic int in_q(int t);
    foreach (mq[i]) if (mq[i].tag == t) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    mq.delete();
    foreach (mdone[i]) mdone[i] = 0;
    mtail = 0;
    e_cv = 0; e_ww = 0; e_arch = 0; e_phy = 0; e_free = 0;
  endtask

  task automatic model_edge();
    int    rdy;
    int    com;
    ment_t h;
    rdy = (mq.size() < N);
    if (flush) begin
      mq.delete();
      foreach (mdone[i]) mdone[i] = 0;
      mtail = 0;
      e_cv = 0;
    end else begin
      com = 0;
      if (mq.size() > 0)
        com = mdone[mq[0].tag] || (BYP && complete_valid && (int'(complete_tag) == mq[0].tag));
      if (complete_valid && in_q(int'(complete_tag))) mdone[complete_tag] = 1;
      e_cv = com;
      if (com) begin
        h = mq.pop_front();
        e_ww = h.ww; e_arch = h.arch; e_phy = h.phy; e_free = h.old;
      end
      if (alloc_valid && rdy) begin
        mq.push_back('{mtail, int'(alloc_with_write), int'(alloc_arch_rd),
                       int'(alloc_phy_rd), int'(alloc_old_phy_rd)});
        mdone[mtail] = 0;
        mtail = (mtail + 1) % N;
      end
    end
  endtask

  task automatic check_all();
    chk("commit_valid", int'(commit_valid), e_cv);
    chk("commit_with_write", int'(commit_with_write), e_ww);
    chk("commit_arch_rd", int'(commit_arch_rd), e_arch);
    chk("commit_phy_rd", int'(commit_phy_rd), e_phy);
    chk("commited_wr_register", int'(commited_wr_register), e_free);
    chk("rob_count", int'(rob_count), mq.size());
    chk("alloc_tag", int'(alloc_tag), mtail);
    chk("alloc_ready", int'(alloc_ready), int'(mq.size() < N));
    chk("rob_empty", int'(rob_empty), int'(mq.size() == 0));
  endtask

  task automatic step(int av, int ww, int arch, int phy, int old, int cv, int ct, int fl);
    @(negedge clk);
    alloc_valid      = av[0];
    alloc_with_write = ww[0];
    alloc_arch_rd    = arch[4:0];
    alloc_phy_rd     = phy[5:0];
    alloc_old_phy_rd = old[5:0];
    complete_valid   = cv[0];
    complete_tag     = ct[3:0];
    flush            = fl[0];
    @(posedge clk);
    #1;
    model_edge();
    check_all();
    if (commit_valid) obs_free.push_back(int'(commited_wr_register));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_values(string where);
    chk({where, " commit_valid"}, int'(commit_valid), 0);
    chk({where, " commit_with_write"}, int'(commit_with_write), 0);
    chk({where, " commited_wr_register"}, int'(commited_wr_register), 0);
    chk({where, " commit_arch_rd"}, int'(commit_arch_rd), 0);
    chk({where, " commit_phy_rd"}, int'(commit_phy_rd), 0);
    chk({where, " rob_empty"}, int'(rob_empty), 1);
    chk({where, " alloc_ready"}, int'(alloc_ready), 1);
    chk({where, " rob_count"}, int'(rob_count), 0);
    chk({where, " alloc_tag"}, int'(alloc_tag), 0);
  endtask

  int cnt_before, tag_before, r, ct;

  initial begin
    model_reset();
    #23;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b1;
    idle(1);

    // In-order commit despite out-of-order completion
    obs_free.delete();
    step(1, 1, 1, 32, 4, 0, 0, 0);
    step(1, 1, 2, 33, 1, 0, 0, 0);
    step(1, 1, 3, 34, 5, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 2, 0);
    idle(2);
    chk("no early commit", obs_free.size(), 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    idle(4);
    chk("commit count", obs_free.size(), 3);
    if (obs_free.size() == 3) begin
      chk("free order 0", obs_free[0], 4);
      chk("free order 1", obs_free[1], 1);
      chk("free order 2", obs_free[2], 5);
    end

    // Fill to full, overflow attempt, wrap-around
    step(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 1, i, 40 + i, i, 0, 0, 0);
    chk("full alloc_ready", int'(alloc_ready), 0);
    chk("full rob_count", int'(rob_count), 16);
    step(1, 1, 9, 9, 9, 0, 0, 0);
    chk("overflow ignored", int'(rob_count), 16);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    chk("after commit alloc_ready", int'(alloc_ready), 1);
    chk("wrap alloc_tag", int'(alloc_tag), 0);
    chk("after commit rob_count", int'(rob_count), 15);

    // Same-cycle allocate and commit
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 1, 1, 1, 0, 0, 0);
    step(1, 0, 2, 2, 2, 1, 0, 0);
    step(1, 0, 3, 3, 3, 1, 1, 0);
    cnt_before = int'(rob_count);
    tag_before = int'(alloc_tag);
    step(1, 0, 4, 4, 4, 1, 2, 0);
    chk("alloc+commit valid", int'(commit_valid), 1);
    chk("alloc+commit count", int'(rob_count), cnt_before);
    chk("alloc+commit tail", int'(alloc_tag), (tag_before + 1) % N);
    idle(3);

    // Flush with done entries present
    step(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, i, 20 + i, i, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 3, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("flush commit_valid", int'(commit_valid), 0);
    chk("flush rob_count", int'(rob_count), 0);
    chk("flush alloc_tag", int'(alloc_tag), 0);
    step(0, 0, 0, 0, 0, 1, 3, 0);
    idle(2);
    chk("stale completion count", int'(rob_count), 0);
    chk("stale completion commit", int'(commit_valid), 0);

    // Completion-to-commit latency
    step(1, 1, 7, 50, 11, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    chk("latency edge k", int'(commit_valid), BYP);
    idle(1);
    chk("latency edge k+1", int'(commit_valid), 1 - BYP);
    idle(1);

    // Randomized traffic with an asynchronous reset in the middle
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_reset_values("midreset");
        alloc_valid = 1'b0; complete_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
      r = $urandom_range(0, 99);
      if (mq.size() > 0 && $urandom_range(0, 9) < 8)
        ct = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        ct = $urandom_range(0, N - 1);
      step(int'(r < 60), $urandom_range(0, 1), $urandom_range(0, 31),
           $urandom_range(0, 63), $urandom_range(0, 63),
           int'($urandom_range(0, 99) < 55), ct, int'(r == 99));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
